// File: rtl/bw_io_dtl_pkg.sv
// Shared types for the DTL pad driver: FSM state encoding and scan-cell bit positions.
package bw_io_dtl_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WEAK   = 2'd1,
        STRONG = 2'd2
    } dtl_drv_st_t;

    localparam int BS_DATA_IDX = 0;
    localparam int BS_OE_IDX   = 1;

endpackage

// File: rtl/bw_io_dtl_drv_bs_if.sv
// Pad-side bundle of the DTL driver: functional inputs, boundary-scan controls and driver outputs.
interface bw_io_dtl_drv_bs_if;

    logic data;
    logic oe;
    logic bs_mode;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic bs_si;
    logic pad_obs;
    logic bs_so;
    logic pad_dout;
    logic pad_oe_wk;
    logic pad_oe_str;
    logic drv_ready;

    modport master (
        output data, oe, bs_mode, capture_dr, shift_dr, update_dr, bs_si, pad_obs,
        input  bs_so, pad_dout, pad_oe_wk, pad_oe_str, drv_ready
    );

    modport slave (
        input  data, oe, bs_mode, capture_dr, shift_dr, update_dr, bs_si, pad_obs,
        output bs_so, pad_dout, pad_oe_wk, pad_oe_str, drv_ready
    );

endinterface

// File: rtl/bw_io_dtl_bscan_cell.sv
// One boundary-scan bit: capture/shift register stage followed by an update latch register.
module bw_io_dtl_bscan_cell (
    input  logic rclk,
    input  logic arst_l,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic cap_d,
    input  logic si,
    output logic sh,
    output logic upd
);

    // NOTE: non-blocking assignments let upd take the pre-edge sh even when sh changes on the same edge.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            sh  <= 1'b0;
            upd <= 1'b0;
        end else begin
            if (capture)
                sh <= cap_d;
            else if (shift)
                sh <= si;
            if (update)
                upd <= sh;
        end
    end

endmodule

// File: rtl/bw_io_dtl_drv_bs.sv
// DTL pad transmitter control: weak->strong enable sequencing plus a 2-bit (oe, data) scan cell.
// Optional BW_IO_DTL_DRV_SLEW_EN: a data change while driving strong re-enters the weak phase.
module bw_io_dtl_drv_bs
    import bw_io_dtl_pkg::*;
#(
    parameter int WK_CYC = 4,
    parameter int CNT_W  = 4
) (
    input logic               rclk,
    input logic               arst_l,
    bw_io_dtl_drv_bs_if.slave pif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WK_CYC - 1);

    dtl_drv_st_t      state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       shreg, upd;
    logic             oe_e, data_e, toggle;
    logic             dout_q, wk_q, str_q;

    assign oe_e   = pif.bs_mode ? upd[BS_OE_IDX]   : pif.oe;
    assign data_e = pif.bs_mode ? upd[BS_DATA_IDX] : pif.data;

`ifdef BW_IO_DTL_DRV_SLEW_EN
    assign toggle = data_e != dout_q;
`else
    assign toggle = 1'b0;
`endif

    // NOTE: next-state and counter get their hold values first so no path through the case infers a latch.
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            OFF: begin
                if (oe_e) begin
                    nxt     = WEAK;
                    cnt_nxt = CNT_LOAD;
                end
            end
            WEAK: begin
                if (!oe_e)
                    nxt = OFF;
                else if (toggle)
                    cnt_nxt = CNT_LOAD;
                else if (cnt == '0)
                    nxt = STRONG;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            STRONG: begin
                if (!oe_e) begin
                    nxt = OFF;
                end else if (toggle) begin
                    nxt     = WEAK;
                    cnt_nxt = CNT_LOAD;
                end
            end
            default: nxt = OFF;
        endcase
    end

    // Enables are registered from the next state so a disable reaches the pad one cycle after oe_e falls.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state  <= OFF;
            cnt    <= '0;
            dout_q <= 1'b0;
            wk_q   <= 1'b0;
            str_q  <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_nxt;
            dout_q <= data_e;
            wk_q   <= nxt != OFF;
            str_q  <= nxt == STRONG;
        end
    end

    // Scan chain: bs_si -> oe bit -> data bit -> bs_so.
    bw_io_dtl_bscan_cell u_cell_oe (
        .rclk    (rclk),
        .arst_l  (arst_l),
        .capture (pif.capture_dr),
        .shift   (pif.shift_dr),
        .update  (pif.update_dr),
        .cap_d   (oe_e),
        .si      (pif.bs_si),
        .sh      (shreg[BS_OE_IDX]),
        .upd     (upd[BS_OE_IDX])
    );

    bw_io_dtl_bscan_cell u_cell_data (
        .rclk    (rclk),
        .arst_l  (arst_l),
        .capture (pif.capture_dr),
        .shift   (pif.shift_dr),
        .update  (pif.update_dr),
        .cap_d   (pif.pad_obs),
        .si      (shreg[BS_OE_IDX]),
        .sh      (shreg[BS_DATA_IDX]),
        .upd     (upd[BS_DATA_IDX])
    );

    assign pif.bs_so      = shreg[BS_DATA_IDX];
    assign pif.pad_dout   = dout_q;
    assign pif.pad_oe_wk  = wk_q;
    assign pif.pad_oe_str = str_q;
    assign pif.drv_ready  = str_q;

endmodule

// File: tb/tb_bw_io_dtl_drv_bs.sv
// Self-checking bench for bw_io_dtl_drv_bs: directed scenarios followed by random stimulus against a
// drive-age reference model. Honours BW_IO_DTL_DRV_SLEW_EN the same way as the design.
module tb_bw_io_dtl_drv_bs;

    localparam int WK_CYC = 4;
`ifdef BW_IO_DTL_DRV_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic rclk;
    logic arst_l;
    int   errors = 0;
    int   checks = 0;

    bw_io_dtl_drv_bs_if dif ();

    bw_io_dtl_drv_bs #(.WK_CYC(WK_CYC), .CNT_W(4)) dut (
        .rclk   (rclk),
        .arst_l (arst_l),
        .pif    (dif)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Model: whether the pad is being driven, and how many edges it has been driven since the weak
    // phase last (re)started. Strong is allowed once that age reaches WK_CYC.
    bit       m_on;
    int       m_age;
    bit       m_dout;
    bit [1:0] m_sh;
    bit [1:0] m_upd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on   = 1'b0;
        m_age  = 0;
        m_dout = 1'b0;
        m_sh   = 2'b00;
        m_upd  = 2'b00;
    endtask

    task automatic check_outputs();
        bit str_exp;
        str_exp = m_on && (m_age >= WK_CYC);
        check("pad_dout",   dif.pad_dout,   m_dout);
        check("pad_oe_wk",  dif.pad_oe_wk,  m_on);
        check("pad_oe_str", dif.pad_oe_str, str_exp);
        check("drv_ready",  dif.drv_ready,  str_exp);
        check("bs_so",      dif.bs_so,      m_sh[0]);
    endtask

    // Advance the model by one rclk edge from the currently applied inputs, then compare at negedge.
    task automatic step();
        bit oe_e, data_e;
        bit [1:0] sh_old;
        oe_e   = dif.bs_mode ? m_upd[1] : dif.oe;
        data_e = dif.bs_mode ? m_upd[0] : dif.data;
        if (!oe_e) begin
            m_on  = 1'b0;
            m_age = 0;
        end else if (!m_on) begin
            m_on  = 1'b1;
            m_age = 0;
        end else if (SLEW && (data_e != m_dout)) begin
            m_age = 0;
        end else if (m_age < 1000) begin
            m_age = m_age + 1;
        end
        m_dout = data_e;
        sh_old = m_sh;
        if (dif.capture_dr)
            m_sh = {oe_e, dif.pad_obs};
        else if (dif.shift_dr)
            m_sh = {dif.bs_si, m_sh[1]};
        if (dif.update_dr)
            m_upd = sh_old;
        @(posedge rclk);
        @(negedge rclk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        dif.data       = 1'b0;
        dif.oe         = 1'b0;
        dif.bs_mode    = 1'b0;
        dif.capture_dr = 1'b0;
        dif.shift_dr   = 1'b0;
        dif.update_dr  = 1'b0;
        dif.bs_si      = 1'b0;
        dif.pad_obs    = 1'b0;
    endtask

    initial begin
        int n_weak;
        idle_inputs();
        model_reset();
        arst_l = 1'b0;
        #12;
        check_outputs();
        @(negedge rclk);
        arst_l = 1'b1;

        // 1: weak phase length after enabling from reset.
        dif.oe = 1'b1;
        dif.data = 1'b1;
        n_weak = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dif.pad_oe_str === 1'b1) break;
            if (dif.pad_oe_wk === 1'b1) n_weak++;
        end
        check("weak_len", n_weak, WK_CYC);
        repeat (2) step();

        // 2: immediate disable, then a full weak phase on re-enable.
        dif.oe = 1'b0;
        step();
        check("off_wk", dif.pad_oe_wk, 1'b0);
        dif.oe = 1'b1;
        repeat (WK_CYC + 2) step();

        // 3: capture {oe, pad_obs}, shift in 1,1, update, then drive from scan.
        dif.oe = 1'b1;
        dif.pad_obs = 1'b0;
        dif.capture_dr = 1'b1;
        step();
        check("cap_so", dif.bs_so, 1'b0);
        dif.capture_dr = 1'b0;
        dif.shift_dr = 1'b1;
        dif.bs_si = 1'b1;
        step();
        check("shift_so", dif.bs_so, 1'b1);
        step();
        dif.shift_dr = 1'b0;
        dif.update_dr = 1'b1;
        dif.oe = 1'b0;
        step();
        dif.update_dr = 1'b0;
        step();
        dif.bs_mode = 1'b1;
        dif.data = 1'b0;
        repeat (WK_CYC + 3) step();
        check("bs_dout", dif.pad_dout, 1'b1);

        // 4: capture beats shift; update takes the pre-edge register value.
        dif.pad_obs = 1'b0;
        dif.capture_dr = 1'b1;
        dif.shift_dr = 1'b1;
        dif.update_dr = 1'b1;
        dif.bs_si = 1'b0;
        step();
        dif.capture_dr = 1'b0;
        dif.shift_dr = 1'b0;
        dif.update_dr = 1'b0;
        repeat (3) step();

        // 5: data toggle while strong (slew behaviour depends on the build).
        dif.bs_mode = 1'b0;
        dif.oe = 1'b1;
        dif.data = 1'b0;
        repeat (WK_CYC + 2) step();
        dif.data = 1'b1;
        repeat (WK_CYC + 2) step();
        dif.data = 1'b0;
        step();
        dif.data = 1'b1;
        repeat (WK_CYC + 2) step();

        // 6: asynchronous reset in the middle of the weak phase.
        dif.oe = 1'b0;
        step();
        dif.oe = 1'b1;
        repeat (2) step();
        #2 arst_l = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge rclk);
        arst_l = 1'b1;
        dif.oe = 1'b0;
        step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) dif.oe = ~dif.oe;
            if ($urandom_range(7) == 0)  dif.data = ~dif.data;
            if ($urandom_range(31) == 0) dif.bs_mode = ~dif.bs_mode;
            dif.capture_dr = ($urandom_range(7) == 0);
            dif.shift_dr   = ($urandom_range(3) == 0);
            dif.update_dr  = ($urandom_range(7) == 0);
            dif.bs_si      = 1'($urandom);
            dif.pad_obs    = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
